vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the CPU load/store path and the VGA scanout fetcher inside mytop.
- VGA scanout normally wins, because it has a hard pixel deadline.
- A starvation guard forces a CPU slot after a bounded wait.
- Memory commands are registered, read data is routed back to the owning requester, and a 16-bit stall counter is exported for the debug bus (dout).

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_rd_pipe.sv | 26 ++
 rtl/vram_arbiter.sv | 114 +++++++++++
 tb/tb_vram_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared widths, owner encoding and read-tag payload for the VRAM arbiter.
package vram_pkg;

  localparam int unsigned ADDR_W_DEF     = 13;
  localparam int unsigned DATA_W_DEF     = 16;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned STARVE_W       = 4;
  localparam int unsigned STALL_W        = 16;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester and RAM-side signals of the VRAM arbiter; slave = arbiter, master = requesters + RAM.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_gnt;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vram_rd_pipe.sv
// Two-deep {valid, owner} shift register aligning read tags with RAM read data.
module vram_rd_pipe
  import vram_pkg::*;
(
  input  logic    clk_in,
  input  logic    rst_in,
  input  rd_tag_t push,
  output rd_tag_t pop
);

  rd_tag_t s1_q;
  rd_tag_t s2_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= push;
      s2_q <= s1_q;
    end
  end

  assign pop = s2_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout has priority, a starvation guard forces CPU slots,
// commands are registered and read data is routed back to its owner two cycles after grant.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  vram_arbiter_if.slave      bus,
  output logic [STALL_W-1:0] stall_cnt
);

  logic                force_cpu;
  logic                vga_win;
  logic                cpu_win;
  logic [STARVE_W-1:0] starve_q;
  logic [STALL_W-1:0]  stall_q;

  logic                cmd_en_q;
  logic                cmd_we_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wdata_q;

  rd_tag_t             rd_push;
  rd_tag_t             rd_pop;
  logic                vga_hit;
  logic                cpu_hit;
  logic [DATA_W-1:0]   vga_hold_q;
  logic [DATA_W-1:0]   cpu_hold_q;

  // Same-cycle grant: VGA wins unless the CPU has waited STARVE_MAX cycles.
  assign force_cpu   = bus.cpu_req && (starve_q == STARVE_W'(STARVE_MAX));
  assign vga_win     = bus.vga_req && !force_cpu;
  assign cpu_win     = bus.cpu_req && !vga_win;
  assign bus.vga_gnt = vga_win;
  assign bus.cpu_gnt = cpu_win;

  // Command register feeding the RAM one cycle after the grant.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cmd_en_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      cmd_en_q <= vga_win || cpu_win;
      cmd_we_q <= cpu_win && bus.cpu_we;
      if (vga_win) begin
        cmd_addr_q <= bus.vga_addr;
      end else if (cpu_win) begin
        cmd_addr_q  <= bus.cpu_addr;
        cmd_wdata_q <= bus.cpu_wdata;
      end
    end
  end

  assign bus.mem_en    = cmd_en_q;
  assign bus.mem_we    = cmd_we_q;
  assign bus.mem_addr  = cmd_addr_q;
  assign bus.mem_wdata = cmd_wdata_q;

  // Starvation guard and saturating stall statistics.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      starve_q <= '0;
      stall_q  <= '0;
    end else begin
      if (cpu_win || !bus.cpu_req) begin
        starve_q <= '0;
      end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
        starve_q <= starve_q + STARVE_W'(1);
      end
      if (bus.cpu_req && !cpu_win && (stall_q != '1)) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;

  // CPU writes never return data, so only reads are tagged.
  assign rd_push.valid = vga_win || (cpu_win && !bus.cpu_we);
  assign rd_push.owner = cpu_win ? OWN_CPU : OWN_VGA;

  vram_rd_pipe u_rd_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rd_push),
    .pop    (rd_pop)
  );

  assign vga_hit = rd_pop.valid && (rd_pop.owner == OWN_VGA);
  assign cpu_hit = rd_pop.valid && (rd_pop.owner == OWN_CPU);

  // Each requester sees live RAM data on its own return and holds it otherwise.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vga_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      if (vga_hit) vga_hold_q <= bus.mem_rdata;
      if (cpu_hit) cpu_hold_q <= bus.mem_rdata;
    end
  end

  assign bus.vga_rvalid = vga_hit;
  assign bus.cpu_rvalid = cpu_hit;
  assign bus.vga_rdata  = vga_hit ? bus.mem_rdata : vga_hold_q;
  assign bus.cpu_rdata  = cpu_hit ? bus.mem_rdata : cpu_hold_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a write-first synchronous RAM model.
module tb_vram_arbiter;
  import vram_pkg::*;

  logic        clk_in;
  logic        rst_in;
  logic [15:0] stall_cnt;
  int          compared;
  int          errs;

  vram_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus ();

  vram_arbiter #(.ADDR_W(13), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // RAM model: preload pattern until a location is first written
  logic [15:0] ram [0:8191];
  logic        written [0:8191];
  logic [15:0] ram_q;

  function automatic logic [15:0] init_val(input logic [12:0] a);
    case (a)
      13'h0010: init_val = 16'hBEEF;
      13'h0100: init_val = 16'hAAAA;
      13'h0200: init_val = 16'h5555;
      default:  init_val = 16'(a) ^ 16'hC3C3;
    endcase
  endfunction

  always @(posedge clk_in) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
        ram_q                 <= bus.mem_wdata;
      end else begin
        ram_q <= (written[bus.mem_addr] === 1'b1) ? ram[bus.mem_addr] : init_val(bus.mem_addr);
      end
    end
  end

  assign bus.mem_rdata = ram_q;

  // Protocol watch: a waiting CPU request must keep its fields stable
  logic        pend;
  logic        held_we;
  logic [12:0] held_addr;
  logic [15:0] held_wdata;

  initial pend = 1'b0;
  always @(negedge clk_in) begin
    if (rst_in && pend && bus.cpu_req) begin
      assert ({held_we, held_addr, held_wdata} === {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata})
      else begin
        errs++;
        $error("FAIL cpu_fields_stable: observed %h expected %h",
               {bus.cpu_we, bus.cpu_addr, bus.cpu_wdata}, {held_we, held_addr, held_wdata});
      end
    end
    pend       = rst_in && bus.cpu_req && !bus.cpu_gnt;
    held_we    = bus.cpu_we;
    held_addr  = bus.cpu_addr;
    held_wdata = bus.cpu_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  int ngnt;
  int last_gnt;
  int bad_gap;

  initial begin
    compared      = 0;
    errs          = 0;
    rst_in        = 1'b0;
    bus.vga_req   = 1'b0;
    bus.vga_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    // Reset values
    sample();
    chk("rst_mem_en",     32'(bus.mem_en),     32'd0);
    chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
    chk("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(bus.mem_wdata),  32'd0);
    chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
    chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst_stall",      32'(stall_cnt),      32'd0);
    tick();
    rst_in = 1'b1;
    tick();

    // 1: single CPU read of 0x0010
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0010;
    sample();
    chk("t1_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    chk("t1_vga_gnt", 32'(bus.vga_gnt), 32'd0);
    tick();
    bus.cpu_req = 1'b0;
    sample();
    chk("t1_mem_en",     32'(bus.mem_en),     32'd1);
    chk("t1_mem_addr",   32'(bus.mem_addr),   32'h0010);
    chk("t1_mem_we",     32'(bus.mem_we),     32'd0);
    chk("t1_cpu_rv_c1",  32'(bus.cpu_rvalid), 32'd0);
    tick();
    sample();
    chk("t1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("t1_cpu_rdata",  32'(bus.cpu_rdata),  32'hBEEF);
    chk("t1_vga_rvalid", 32'(bus.vga_rvalid), 32'd0);
    tick();
    sample();
    chk("t1_cpu_rv_c3",  32'(bus.cpu_rvalid), 32'd0);
    chk("t1_cpu_hold",   32'(bus.cpu_rdata),  32'hBEEF);
    chk("t1_mem_en_c3",  32'(bus.mem_en),     32'd0);

    // 2: write 0x1234 to 0x0020, read it back the next cycle
    tick();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 13'h0020; bus.cpu_wdata = 16'h1234;
    sample();
    chk("t2_wr_gnt", 32'(bus.cpu_gnt), 32'd1);
    tick();
    bus.cpu_we = 1'b0;
    sample();
    chk("t2_mem_we",    32'(bus.mem_we),     32'd1);
    chk("t2_mem_wdata", 32'(bus.mem_wdata),  32'h1234);
    chk("t2_mem_addr",  32'(bus.mem_addr),   32'h0020);
    chk("t2_rd_gnt",    32'(bus.cpu_gnt),    32'd1);
    tick();
    bus.cpu_req = 1'b0;
    sample();
    chk("t2_rd_mem_we", 32'(bus.mem_we),     32'd0);
    chk("t2_wr_norv",   32'(bus.cpu_rvalid), 32'd0);
    tick();
    sample();
    chk("t2_rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("t2_rd_rdata",  32'(bus.cpu_rdata),  32'h1234);
    tick();
    sample();
    chk("t2_rv_drop",   32'(bus.cpu_rvalid), 32'd0);

    // 3: VGA held, CPU forced in on the 5th waiting cycle
    tick();
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h0200;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("t3_vga_gnt_%0d", k), 32'(bus.vga_gnt),   32'd1);
      chk($sformatf("t3_cpu_gnt_%0d", k), 32'(bus.cpu_gnt),   32'd0);
      chk($sformatf("t3_starve_%0d", k),  32'(dut.starve_q),  32'(k));
      tick();
    end
    sample();
    chk("t3_forced_cpu", 32'(bus.cpu_gnt), 32'd1);
    chk("t3_forced_vga", 32'(bus.vga_gnt), 32'd0);
    chk("t3_stall",      32'(stall_cnt),   32'd4);
    tick();
    bus.cpu_req = 1'b0;
    sample();
    chk("t3_vga_regnt",  32'(bus.vga_gnt),  32'd1);
    chk("t3_starve_clr", 32'(dut.starve_q), 32'd0);
    chk("t3_stall_hold", 32'(stall_cnt),    32'd4);
    tick();
    bus.vga_req = 1'b0;
    tick();
    tick();
    tick();

    // 4: alternating VGA 0x0100 / CPU 0x0200 reads
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0100;
    sample();
    chk("t4_a_vga_gnt", 32'(bus.vga_gnt), 32'd1);
    tick();
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_addr = 13'h0200;
    sample();
    chk("t4_b_cpu_gnt", 32'(bus.cpu_gnt),    32'd1);
    chk("t4_b_vga_rv",  32'(bus.vga_rvalid), 32'd0);
    tick();
    bus.cpu_req = 1'b0;
    bus.vga_req = 1'b1;
    sample();
    chk("t4_c_vga_gnt", 32'(bus.vga_gnt),    32'd1);
    chk("t4_c_vga_rv",  32'(bus.vga_rvalid), 32'd1);
    chk("t4_c_vga_rd",  32'(bus.vga_rdata),  32'hAAAA);
    chk("t4_c_cpu_rv",  32'(bus.cpu_rvalid), 32'd0);
    tick();
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b1;
    sample();
    chk("t4_d_cpu_gnt", 32'(bus.cpu_gnt),    32'd1);
    chk("t4_d_cpu_rv",  32'(bus.cpu_rvalid), 32'd1);
    chk("t4_d_cpu_rd",  32'(bus.cpu_rdata),  32'h5555);
    chk("t4_d_vga_rv",  32'(bus.vga_rvalid), 32'd0);
    chk("t4_d_vga_hold",32'(bus.vga_rdata),  32'hAAAA);
    tick();
    bus.cpu_req = 1'b0;
    sample();
    chk("t4_e_vga_rv",  32'(bus.vga_rvalid), 32'd1);
    chk("t4_e_vga_rd",  32'(bus.vga_rdata),  32'hAAAA);
    chk("t4_e_cpu_rv",  32'(bus.cpu_rvalid), 32'd0);
    tick();
    sample();
    chk("t4_f_cpu_rv",  32'(bus.cpu_rvalid), 32'd1);
    chk("t4_f_cpu_rd",  32'(bus.cpu_rdata),  32'h5555);
    chk("t4_f_vga_rv",  32'(bus.vga_rvalid), 32'd0);

    // 5: asynchronous reset with a CPU read in flight
    tick();
    tick();
    bus.cpu_req = 1'b1; bus.cpu_addr = 13'h0010;
    sample();
    chk("t5_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    tick();
    bus.cpu_req = 1'b0;
    rst_in = 1'b0;
    #1;
    chk("t5_async_mem_en",   32'(bus.mem_en),     32'd0);
    chk("t5_async_mem_addr", 32'(bus.mem_addr),   32'd0);
    chk("t5_async_cpu_rd",   32'(bus.cpu_rdata),  32'd0);
    chk("t5_async_vga_rd",   32'(bus.vga_rdata),  32'd0);
    chk("t5_async_stall",    32'(stall_cnt),      32'd0);
    tick();
    sample();
    chk("t5_rst_cpu_rv", 32'(bus.cpu_rvalid), 32'd0);
    tick();
    rst_in = 1'b1;
    sample();
    chk("t5_post_cpu_rv0", 32'(bus.cpu_rvalid), 32'd0);
    tick();
    sample();
    chk("t5_post_cpu_rv1", 32'(bus.cpu_rvalid), 32'd0);
    tick();
    bus.cpu_req = 1'b1;
    sample();
    chk("t5_re_gnt", 32'(bus.cpu_gnt), 32'd1);
    tick();
    bus.cpu_req = 1'b0;
    tick();
    sample();
    chk("t5_re_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    chk("t5_re_rdata",  32'(bus.cpu_rdata),  32'hBEEF);

    // 6: permanent contention, stall counter saturation
    tick();
    bus.vga_req = 1'b1; bus.vga_addr = 13'h0100;
    bus.cpu_req = 1'b1; bus.cpu_addr = 13'h0200;
    ngnt     = 0;
    last_gnt = -1;
    bad_gap  = 0;
    for (int i = 0; i < 82000; i++) begin
      sample();
      if (i == 50000) chk("t6_stall_mid", 32'(stall_cnt), 32'd40000);
      if (bus.cpu_gnt) begin
        if (last_gnt >= 0 && (i - last_gnt) != 5) bad_gap++;
        if (last_gnt < 0 && i != 4) bad_gap++;
        ngnt++;
        last_gnt = i;
      end
      tick();
    end
    sample();
    chk("t6_stall_sat", 32'(stall_cnt), 32'h0000FFFF);
    chk("t6_gnt_count", 32'(ngnt),      32'd16400);
    chk("t6_gnt_gaps",  32'(bad_gap),   32'd0);
    tick();
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end

endmodule
